// File: rtl/rx_ctrl_exe.sv
// Command executor: filters decoded commands on device ID, runs a register write/read,
// and returns a 4-byte response frame. Optional macro RX_CTRL_EXE_WR_ECHO_EN enables write responses.
module rx_ctrl_exe #(
    parameter logic [7:0]  DEV_ID = 8'h01,
    parameter logic [15:0] ACK_TO = 16'd50000,
    parameter logic [7:0]  MOD_WR = 8'h01,
    parameter logic [7:0]  MOD_RD = 8'h02
) (
    input  logic       clk_sys,
    input  logic       rst,
    input  logic [7:0] cmdr_dev,
    input  logic [7:0] cmdr_mod,
    input  logic [7:0] cmdr_addr,
    input  logic [7:0] cmdr_data,
    input  logic       cmdr_vld,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_wr,
    output logic       reg_rd,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic [7:0] tx_data,
    output logic       tx_vld,
    input  logic       tx_rdy,
    output logic       busy,
    output logic [7:0] drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  dev_q, mod_q, addr_q, data_q, result_q;
    logic        err_q;
    logic [15:0] to_cnt;
    logic [2:0]  byte_idx;
    logic        tx_vld_q;
    logic        timeout;

    assign timeout = (to_cnt == ACK_TO);

    // NOTE: every output of this block is assigned a default first so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        reg_wr    = 1'b0;
        reg_rd    = 1'b0;
        tx_vld    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmdr_vld && cmdr_dev == DEV_ID) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (mod_q == MOD_WR) begin
                    reg_wr    = 1'b1;
                    state_nxt = S_WAIT;
                end else if (mod_q == MOD_RD) begin
                    reg_rd    = 1'b1;
                    state_nxt = S_WAIT;
                end else begin
                    state_nxt = S_RESP;
                end
            end
            S_WAIT: begin
                if (reg_ack) begin
`ifdef RX_CTRL_EXE_WR_ECHO_EN
                    state_nxt = S_RESP;
`else
                    state_nxt = (mod_q == MOD_WR) ? S_IDLE : S_RESP;
`endif
                end else if (timeout) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                // A byte never follows another in the very next cycle.
                if (tx_rdy && !tx_vld_q) begin
                    tx_vld = 1'b1;
                    if (byte_idx == 3'd3) state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            dev_q    <= '0;
            mod_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            to_cnt   <= '0;
            byte_idx <= '0;
            tx_vld_q <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state    <= state_nxt;
            tx_vld_q <= tx_vld;

            if (state == S_IDLE && cmdr_vld) begin
                dev_q    <= cmdr_dev;
                mod_q    <= cmdr_mod;
                addr_q   <= cmdr_addr;
                data_q   <= cmdr_data;
                result_q <= '0;
                err_q    <= 1'b0;
            end

            if (state != S_IDLE && cmdr_vld && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;

            to_cnt <= (state == S_WAIT) ? to_cnt + 16'd1 : 16'd0;

            if (state == S_ISSUE && mod_q != MOD_WR && mod_q != MOD_RD)
                err_q <= 1'b1;

            // An ack arriving together with the timeout still counts as success.
            if (state == S_WAIT) begin
                if (reg_ack)
                    result_q <= (mod_q == MOD_RD) ? reg_rdata : data_q;
                else if (timeout)
                    err_q <= 1'b1;
            end

            if (state != S_RESP)
                byte_idx <= '0;
            else if (tx_vld)
                byte_idx <= byte_idx + 3'd1;
        end
    end

    assign reg_addr  = addr_q;
    assign reg_wdata = data_q;
    assign busy      = (state != S_IDLE);

    always_comb begin
        tx_data = 8'h00;
        if (tx_vld) begin
            case (byte_idx)
                3'd0:    tx_data = dev_q;
                3'd1:    tx_data = err_q ? (mod_q | 8'h80) : mod_q;
                3'd2:    tx_data = addr_q;
                default: tx_data = err_q ? 8'hEE : result_q;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_ctrl_exe.sv
// Self-checking bench for rx_ctrl_exe: vector table, random commands against a frame-level model,
// busy-drop saturation and reset during a response.
module tb_rx_ctrl_exe;

    localparam logic [15:0] ACK_TO = 16'd400;
    localparam int          TO     = 400;
`ifdef RX_CTRL_EXE_WR_ECHO_EN
    localparam bit ECHO = 1'b1;
`else
    localparam bit ECHO = 1'b0;
`endif

    logic       clk_sys = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] cmdr_dev = '0, cmdr_mod = '0, cmdr_addr = '0, cmdr_data = '0;
    logic       cmdr_vld = 1'b0;
    logic [7:0] reg_addr, reg_wdata, reg_rdata = '0, tx_data, drop_cnt;
    logic       reg_wr, reg_rd, reg_ack = 1'b0, tx_vld, tx_rdy = 1'b0, busy;

    rx_ctrl_exe #(.ACK_TO(ACK_TO)) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .cmdr_dev (cmdr_dev),
        .cmdr_mod (cmdr_mod),
        .cmdr_addr(cmdr_addr),
        .cmdr_data(cmdr_data),
        .cmdr_vld (cmdr_vld),
        .reg_addr (reg_addr),
        .reg_wdata(reg_wdata),
        .reg_wr   (reg_wr),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata),
        .reg_ack  (reg_ack),
        .tx_data  (tx_data),
        .tx_vld   (tx_vld),
        .tx_rdy   (tx_rdy),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Environment state shared by the monitor and the bus/tx responders.
    int         cyc = 0;
    int         ack_delay = 0;
    int         ack_cnt = 0;
    logic [7:0] rd_val = '0;
    int         tx_mode = 0;
    logic [7:0] got_q[$];
    int         n_wr = 0, n_rd = 0;
    logic [7:0] st_addr = '0, st_wdata = '0;
    bit         busy_seen = 1'b0;
    int         first_tx_cyc = -1;
    bit         prev_vld = 1'b0;
    int         exp_drop = 0;

    always @(posedge clk_sys) cyc = cyc + 1;

    always @(negedge clk_sys) begin
        if (busy) busy_seen = 1'b1;
        if (reg_wr) begin
            n_wr++;
            st_addr  = reg_addr;
            st_wdata = reg_wdata;
        end
        if (reg_rd) begin
            n_rd++;
            st_addr = reg_addr;
        end
        if ((reg_wr || reg_rd) && ack_delay > 0) ack_cnt = ack_delay;
        if (tx_vld) begin
            if (got_q.size() == 0) first_tx_cyc = cyc;
            got_q.push_back(tx_data);
            check("tx_spacing", {31'd0, prev_vld}, 32'd0);
            check("tx_rdy_at_vld", {31'd0, tx_rdy}, 32'd1);
        end
        prev_vld = tx_vld;
    end

    always @(posedge clk_sys) begin
        #1;
        reg_ack   = 1'b0;
        reg_rdata = 8'($urandom);
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) begin
                reg_ack   = 1'b1;
                reg_rdata = rd_val;
            end
        end
        case (tx_mode)
            0:       tx_rdy = 1'b1;
            1:       tx_rdy = ($urandom_range(0, 2) == 0);
            default: tx_rdy = ((cyc / 4) % 2) == 1;
        endcase
    end

    // Frame-level reference: dly is the ack distance in cycles after the strobe (0 = never).
    // The bus waits ACK_TO+1 cycles, so an ack up to TO+1 cycles after the strobe is in time.
    function automatic void model(input logic [7:0] dev, mod, addr, data, rdata, input int dly,
                                  output bit resp, output logic [31:0] frame,
                                  output int nwr, output int nrd);
        bit ok;
        nwr = 0; nrd = 0; resp = 1'b0; frame = '0;
        if (dev != 8'h01) return;
        if (mod == 8'h01) nwr = 1;
        else if (mod == 8'h02) nrd = 1;
        ok = (nwr + nrd == 1) && dly >= 1 && dly <= TO + 1;
        if (ok) begin
            resp  = (nrd == 1) || ECHO;
            frame = {dev, mod, addr, (nrd == 1) ? rdata : data};
        end else begin
            resp  = 1'b1;
            frame = {dev, mod | 8'h80, addr, 8'hEE};
        end
    endfunction

    task automatic run_cmd(input string tag, input logic [7:0] dev, mod, addr, data, rdata,
                           input int dly, mode, spam, exp_lat,
                           input bit exp_resp, input logic [31:0] exp_frame,
                           input int exp_wr, exp_rd);
        int v, t, budget;
        logic [31:0] frame;
        got_q.delete();
        n_wr = 0; n_rd = 0; busy_seen = 1'b0; first_tx_cyc = -1;
        ack_delay = dly; rd_val = rdata; tx_mode = mode;
        budget = TO + 400 + spam;
        tick();
        cmdr_dev = dev; cmdr_mod = mod; cmdr_addr = addr; cmdr_data = data; cmdr_vld = 1'b1;
        v = cyc;
        tick();
        cmdr_vld = 1'b0;
        if (spam > 0) begin
            tick();
            repeat (spam) begin
                cmdr_dev = 8'h01; cmdr_mod = 8'($urandom); cmdr_addr = 8'($urandom);
                cmdr_vld = 1'b1;
                tick();
            end
            cmdr_vld = 1'b0;
            exp_drop = (exp_drop + spam > 255) ? 255 : exp_drop + spam;
        end
        t = 0;
        if (exp_resp) begin
            while (got_q.size() < 4 && t < budget) begin tick(); t++; end
        end else begin
            repeat ((dly > 0 ? dly : 0) + 20) tick();
        end
        while (ack_cnt > 0 && t < budget) begin tick(); t++; end
        repeat (6) tick();

        check({tag, ".n_bytes"}, got_q.size(), exp_resp ? 4 : 0);
        if (exp_resp && got_q.size() == 4) begin
            frame = {got_q[0], got_q[1], got_q[2], got_q[3]};
            check({tag, ".frame"}, frame, exp_frame);
            if (exp_lat > 0) check({tag, ".latency"}, first_tx_cyc - v, exp_lat);
        end
        check({tag, ".n_wr"}, n_wr, exp_wr);
        check({tag, ".n_rd"}, n_rd, exp_rd);
        if (exp_wr + exp_rd > 0) check({tag, ".strobe_addr"}, st_addr, addr);
        if (exp_wr > 0) check({tag, ".strobe_wdata"}, st_wdata, data);
        check({tag, ".busy_seen"}, {31'd0, busy_seen}, (dev == 8'h01) ? 1 : 0);
        check({tag, ".busy_end"}, {31'd0, busy}, 0);
        check({tag, ".drop_cnt"}, drop_cnt, exp_drop);
    endtask

    typedef struct {
        logic [7:0]  dev, mod, addr, data, rdata;
        int          dly, mode, exp_lat;
        bit          exp_resp;
        logic [31:0] exp_frame;
        int          exp_wr, exp_rd;
    } vec_t;

    vec_t vecs[13];

    initial begin
        bit          r_resp;
        logic [31:0] r_frame;
        int          r_wr, r_rd, r_dly;
        logic [7:0]  r_dev, r_mod, r_addr, r_data, r_rdata;
        int          t;

        vecs[0]  = '{8'h01, 8'h01, 8'h10, 8'h5A, 8'h00, 2,      0, ECHO ? 4 : 0,   ECHO, 32'h0101105A, 1, 0};
        vecs[1]  = '{8'h01, 8'h01, 8'h33, 8'h7E, 8'h00, 1,      0, ECHO ? 3 : 0,   ECHO, 32'h0101337E, 1, 0};
        vecs[2]  = '{8'h01, 8'h02, 8'h20, 8'h00, 8'hC3, 1,      0, 3,              1'b1, 32'h010220C3, 0, 1};
        vecs[3]  = '{8'h01, 8'h02, 8'h44, 8'h12, 8'h96, 2,      2, 0,              1'b1, 32'h01024496, 0, 1};
        vecs[4]  = '{8'h07, 8'h01, 8'h55, 8'hAA, 8'h00, 1,      0, 0,              1'b0, 32'h0,        0, 0};
        vecs[5]  = '{8'hFE, 8'h02, 8'h56, 8'h00, 8'h11, 1,      0, 0,              1'b0, 32'h0,        0, 0};
        vecs[6]  = '{8'h01, 8'h05, 8'h60, 8'h11, 8'h00, 0,      0, 2,              1'b1, 32'h018560EE, 0, 0};
        vecs[7]  = '{8'h01, 8'h00, 8'h61, 8'h22, 8'h00, 0,      1, 0,              1'b1, 32'h018061EE, 0, 0};
        vecs[8]  = '{8'h01, 8'h02, 8'h70, 8'h00, 8'h99, 0,      0, TO + 3,         1'b1, 32'h018270EE, 0, 1};
        vecs[9]  = '{8'h01, 8'h02, 8'h71, 8'h00, 8'h3C, TO + 1, 0, TO + 3,         1'b1, 32'h0102713C, 0, 1};
        vecs[10] = '{8'h01, 8'h02, 8'h72, 8'h00, 8'h3D, TO + 2, 0, TO + 3,         1'b1, 32'h018272EE, 0, 1};
        vecs[11] = '{8'h01, 8'h01, 8'h73, 8'h44, 8'h00, 0,      0, TO + 3,         1'b1, 32'h018173EE, 1, 0};
        vecs[12] = '{8'h01, 8'hFF, 8'h74, 8'h00, 8'h00, 0,      2, 0,              1'b1, 32'h01FF74EE, 0, 0};

        // Reset state
        @(negedge clk_sys);
        @(negedge clk_sys);
        check("rst.busy", {31'd0, busy}, 0);
        check("rst.tx_vld", {31'd0, tx_vld}, 0);
        check("rst.reg_wr", {31'd0, reg_wr}, 0);
        check("rst.reg_rd", {31'd0, reg_rd}, 0);
        check("rst.drop_cnt", drop_cnt, 0);
        check("rst.reg_addr", reg_addr, 0);
        check("rst.reg_wdata", reg_wdata, 0);
        check("rst.tx_data", tx_data, 0);
        tick();
        rst = 1'b0;
        repeat (3) tick();

        for (int i = 0; i < 13; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].dev, vecs[i].mod, vecs[i].addr, vecs[i].data,
                    vecs[i].rdata, vecs[i].dly, vecs[i].mode, 0, vecs[i].exp_lat,
                    vecs[i].exp_resp, vecs[i].exp_frame, vecs[i].exp_wr, vecs[i].exp_rd);
        end

        for (int i = 0; i < 40; i++) begin
            r_dev = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(2, 255)) : 8'h01;
            case ($urandom_range(0, 4))
                0, 1:    r_mod = 8'h01;
                2, 3:    r_mod = 8'h02;
                default: r_mod = 8'($urandom_range(3, 255));
            endcase
            r_addr  = 8'($urandom);
            r_data  = 8'($urandom);
            r_rdata = 8'($urandom);
            r_dly   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
            model(r_dev, r_mod, r_addr, r_data, r_rdata, r_dly, r_resp, r_frame, r_wr, r_rd);
            run_cmd($sformatf("rnd%0d", i), r_dev, r_mod, r_addr, r_data, r_rdata, r_dly,
                    $urandom_range(0, 2), 0, 0, r_resp, r_frame, r_wr, r_rd);
        end

        // 300 matching pulses while waiting on the bus saturate drop_cnt; the read still completes.
        run_cmd("busy_drop", 8'h01, 8'h02, 8'h80, 8'h00, 8'h5D, 320, 0, 300, 0,
                1'b1, 32'h0102805D, 0, 1);
        run_cmd("after_drop", 8'h01, 8'h02, 8'h81, 8'h00, 8'h6E, 1, 1, 0, 0,
                1'b1, 32'h0102816E, 0, 1);

        // Reset after the second byte of a slowly paced response.
        got_q.delete();
        ack_delay = 1; rd_val = 8'hA5; tx_mode = 2;
        tick();
        cmdr_dev = 8'h01; cmdr_mod = 8'h02; cmdr_addr = 8'h90; cmdr_vld = 1'b1;
        tick();
        cmdr_vld = 1'b0;
        t = 0;
        while (got_q.size() < 2 && t < 200) begin tick(); t++; end
        check("mid_rst.bytes_before", got_q.size(), 2);
        rst = 1'b1;
        @(negedge clk_sys);
        check("mid_rst.busy", {31'd0, busy}, 0);
        check("mid_rst.tx_vld", {31'd0, tx_vld}, 0);
        check("mid_rst.drop_cnt", drop_cnt, 0);
        check("mid_rst.reg_addr", reg_addr, 0);
        check("mid_rst.tx_data", tx_data, 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (40) tick();
        check("mid_rst.bytes_after", got_q.size(), 2);
        check("mid_rst.busy_after", {31'd0, busy}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
